// File: rtl/phys_reg_free_list_pkg.sv
// Shared types and the reset-image helper for the physical register free list.
package phys_reg_free_list_pkg;

  localparam int P_PHYS_ADDR_BITS = 6;
  localparam int P_NUM_ARCH_REGS  = 32;

  typedef logic [P_PHYS_ADDR_BITS-1:0] preg_t;

  // Entry i of the reset image holds the first unmapped preg plus i.
  function automatic int reset_image_entry(input int num_arch_regs, input int idx);
    return num_arch_regs + idx;
  endfunction

endpackage

// File: rtl/phys_reg_free_list_fifo.sv
// Circular buffer of preg specifiers with a preloaded reset image, push/pop and occupancy count.
module free_list_fifo
  import phys_reg_free_list_pkg::*;
#(
  parameter int p_addr_bits    = 6,
  parameter int p_init_entries = 32,
  parameter int p_init_base    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [p_addr_bits-1:0] push_data,
  input  logic                 pop,
  output logic [p_addr_bits-1:0] head_data,
  output logic [p_addr_bits:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 1 << p_addr_bits;
  localparam logic [p_addr_bits:0] FULL_COUNT = {1'b1, {p_addr_bits{1'b0}}};

  logic [p_addr_bits-1:0] entries [DEPTH];
  logic [p_addr_bits-1:0] head;
  logic [p_addr_bits-1:0] tail;

  // Pointers are exactly p_addr_bits wide, so increments wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= p_addr_bits'(p_init_entries);
      count <= (p_addr_bits+1)'(p_init_entries);
      for (int i = 0; i < DEPTH; i++) begin
        if (i < p_init_entries) begin
          entries[i] <= p_addr_bits'(reset_image_entry(p_init_base, i));
        end
      end
    end else begin
      if (push) begin
        entries[tail] <= push_data;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head_data = entries[head];
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: hands out one free preg per cycle and reclaims committed ppregs.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int p_phys_addr_bits = P_PHYS_ADDR_BITS,
  parameter int p_num_arch_regs  = P_NUM_ARCH_REGS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_en,
  output logic                        alloc_rdy,
  output logic [p_phys_addr_bits-1:0] alloc_preg,
  input  logic                        commit_val,
  input  logic                        commit_wen,
  input  logic [p_phys_addr_bits-1:0] commit_ppreg,
  output logic [p_phys_addr_bits:0]   free_count,
  output logic                        overflow_err
);

  localparam int DEPTH        = 1 << p_phys_addr_bits;
  localparam int INIT_ENTRIES = DEPTH - p_num_arch_regs;

  logic                        free_fire;
  logic                        free_accept;
  logic                        alloc_fire;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [p_phys_addr_bits-1:0] head_data;
  logic [p_phys_addr_bits:0]   count;

  assign free_fire   = commit_val & commit_wen;
  assign free_accept = free_fire & ~fifo_full;
  assign alloc_fire  = alloc_en & alloc_rdy;

  free_list_fifo #(
    .p_addr_bits    (p_phys_addr_bits),
    .p_init_entries (INIT_ENTRIES),
    .p_init_base    (p_num_arch_regs)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (free_accept),
    .push_data (commit_ppreg),
    .pop       (alloc_fire),
    .head_data (head_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // No bypass: a preg freed this cycle only becomes visible once it is in the buffer.
  assign alloc_rdy  = ~fifo_empty;
  assign alloc_preg = alloc_rdy ? head_data : '0;
  assign free_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (free_fire && fifo_full) begin
      overflow_err <= 1'b1;
    end
  end

  a_alloc_when_empty : assert property (@(posedge clk) disable iff (rst) !(alloc_en && !alloc_rdy))
    else $error("phys_reg_free_list: alloc_en asserted with no free preg");

  a_no_x_inputs : assert property (@(posedge clk) disable iff (rst) !$isunknown({alloc_en, commit_val}))
    else $error("phys_reg_free_list: X on alloc_en/commit_val");

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue model predicts allocation order and occupancy.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  localparam int W     = 6;
  localparam int NUM   = 32;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_en = 1'b0;
  logic        commit_val = 1'b0;
  logic        commit_wen = 1'b0;
  preg_t       commit_ppreg = '0;
  logic        alloc_rdy;
  preg_t       alloc_preg;
  logic [W:0]  free_count;
  logic        overflow_err;

  int   vectors = 0;
  int   miscompares = 0;
  int   trace_level = 0;
  int   model_q[$];
  logic model_ovf;
  int   exp_q[$];
  logic obs_rdy;
  preg_t obs_preg;

  phys_reg_free_list #(.p_phys_addr_bits(W), .p_num_arch_regs(NUM)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_rdy    (alloc_rdy),
    .alloc_preg   (alloc_preg),
    .commit_val   (commit_val),
    .commit_wen   (commit_wen),
    .commit_ppreg (commit_ppreg),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic trace(input int level, input logic a, input logic f, input int p);
    if (level > 0)
      $display("trace: alloc=%s free=%s", a ? $sformatf("%0d", obs_preg) : "-", f ? $sformatf("%0d", p) : "-");
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    for (int i = 0; i < DEPTH - NUM; i++) model_q.push_back(NUM + i);
    model_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; alloc_en = 1'b0; commit_val = 1'b0; commit_wen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; captures pre-edge outputs and advances the model.
  task automatic apply(input logic a, input logic v, input logic w, input int p);
    bit full;
    @(negedge clk);
    alloc_en = a; commit_val = v; commit_wen = w; commit_ppreg = preg_t'(p);
    obs_rdy = alloc_rdy; obs_preg = alloc_preg;
    if (a && model_q.size() > 0) exp_q.push_back(model_q[0]);
    full = (model_q.size() == DEPTH);
    @(posedge clk); #1;
    if (a && model_q.size() > 0) void'(model_q.pop_front());
    if (v && w) begin
      if (full) model_ovf = 1'b1;
      else model_q.push_back(p);
    end
    alloc_en = 1'b0; commit_val = 1'b0; commit_wen = 1'b0;
    trace(trace_level, a, v && w, p);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b want 1", alloc_rdy); end
    vectors++; if (free_count !== 7'd32) begin miscompares++; $display("FAIL reset_count: got %0d want 32", free_count); end
    vectors++; if (alloc_preg !== 6'd32) begin miscompares++; $display("FAIL reset_preg: got %0d want 32", alloc_preg); end
    vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
  endtask

  task automatic test_alloc_three();
    int exp;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0);
      exp = exp_q.pop_front();
      vectors++; if (obs_rdy !== 1'b1 || obs_preg !== preg_t'(exp) || exp != 32 + i) begin
        miscompares++; $display("FAIL alloc3[%0d]: got rdy=%b preg=%0d want rdy=1 preg=%0d", i, obs_rdy, obs_preg, 32 + i);
      end
    end
    vectors++; if (free_count !== 7'd29) begin miscompares++; $display("FAIL alloc3_count: got %0d want 29", free_count); end
  endtask

  task automatic test_drain_bypass();
    int exp;
    for (int i = 0; i < 29; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0);
      exp = exp_q.pop_front();
      vectors++; if (obs_preg !== preg_t'(exp)) begin
        miscompares++; $display("FAIL drain[%0d]: got %0d want %0d", i, obs_preg, exp);
      end
    end
    vectors++; if (alloc_rdy !== 1'b0 || free_count !== 7'd0 || alloc_preg !== 6'd0) begin
      miscompares++; $display("FAIL empty_state: got rdy=%b count=%0d preg=%0d want 0/0/0", alloc_rdy, free_count, alloc_preg);
    end
    apply(1'b0, 1'b1, 1'b1, 5);
    vectors++; if (obs_rdy !== 1'b0) begin miscompares++; $display("FAIL no_bypass: got rdy=%b want 0", obs_rdy); end
    vectors++; if (alloc_rdy !== 1'b1 || alloc_preg !== 6'd5 || free_count !== 7'd1) begin
      miscompares++; $display("FAIL after_free: got rdy=%b preg=%0d count=%0d want 1/5/1", alloc_rdy, alloc_preg, free_count);
    end
  endtask

  task automatic test_simultaneous();
    int exp;
    for (int i = 0; i < 9; i++) apply(1'b0, 1'b1, 1'b1, 40 + i);
    vectors++; if (free_count !== 7'd10) begin miscompares++; $display("FAIL simul_setup: got %0d want 10", free_count); end
    apply(1'b1, 1'b1, 1'b1, 7);
    exp = exp_q.pop_front();
    vectors++; if (obs_preg !== preg_t'(exp)) begin miscompares++; $display("FAIL simul_alloc: got %0d want %0d", obs_preg, exp); end
    vectors++; if (free_count !== 7'd10) begin miscompares++; $display("FAIL simul_count: got %0d want 10", free_count); end
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0);
      exp = exp_q.pop_front();
      vectors++; if (obs_preg !== preg_t'(exp)) begin miscompares++; $display("FAIL simul_drain[%0d]: got %0d want %0d", i, obs_preg, exp); end
    end
    vectors++; if (obs_preg !== 6'd7) begin miscompares++; $display("FAIL simul_last: got %0d want 7", obs_preg); end
  endtask

  task automatic test_no_wen();
    int exp;
    logic [W:0] cnt_before;
    preg_t preg_before;
    apply(1'b0, 1'b1, 1'b1, 20);
    apply(1'b0, 1'b1, 1'b1, 21);
    cnt_before = free_count; preg_before = alloc_preg;
    apply(1'b0, 1'b1, 1'b0, 9);
    vectors++; if (free_count !== cnt_before || free_count !== 7'd2) begin
      miscompares++; $display("FAIL nowen_count: got %0d want 2", free_count);
    end
    vectors++; if (alloc_preg !== preg_before || alloc_preg !== 6'd20) begin
      miscompares++; $display("FAIL nowen_preg: got %0d want 20", alloc_preg);
    end
    apply(1'b0, 1'b1, 1'b1, 11);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0);
      exp = exp_q.pop_front();
      vectors++; if (obs_preg !== preg_t'(exp)) begin miscompares++; $display("FAIL nowen_order[%0d]: got %0d want %0d", i, obs_preg, exp); end
    end
    vectors++; if (obs_preg !== 6'd11) begin miscompares++; $display("FAIL nowen_tail: got %0d want 11", obs_preg); end
  endtask

  task automatic test_overflow_wrap();
    int exp;
    do_reset();
    for (int i = 0; i < 32; i++) apply(1'b0, 1'b1, 1'b1, i);
    vectors++; if (free_count !== 7'd64 || overflow_err !== 1'b0) begin
      miscompares++; $display("FAIL full_state: got count=%0d ovf=%b want 64/0", free_count, overflow_err);
    end
    apply(1'b0, 1'b1, 1'b1, 50);
    vectors++; if (free_count !== 7'd64 || overflow_err !== model_ovf || model_ovf !== 1'b1) begin
      miscompares++; $display("FAIL overflow: got count=%0d ovf=%b want 64/1", free_count, overflow_err);
    end
    for (int i = 0; i < 64; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0);
      exp = exp_q.pop_front();
      vectors++; if (obs_preg !== preg_t'(exp) || exp != ((i < 32) ? 32 + i : i - 32)) begin
        miscompares++; $display("FAIL wrap[%0d]: got %0d want %0d", i, obs_preg, (i < 32) ? 32 + i : i - 32);
      end
    end
    vectors++; if (alloc_rdy !== 1'b0 || overflow_err !== 1'b1) begin
      miscompares++; $display("FAIL wrap_end: got rdy=%b ovf=%b want 0/1", alloc_rdy, overflow_err);
    end
  endtask

  task automatic test_mid_reset();
    int exp;
    for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, 1'b1, 10 + i);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0);
      exp = exp_q.pop_front();
      vectors++; if (obs_preg !== preg_t'(exp)) begin miscompares++; $display("FAIL mid_alloc[%0d]: got %0d want %0d", i, obs_preg, exp); end
    end
    apply(1'b0, 1'b1, 1'b1, 3);
    apply(1'b0, 1'b1, 1'b1, 4);
    vectors++; if (free_count !== 7'd4 || overflow_err !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset: got count=%0d ovf=%b want 4/1", free_count, overflow_err);
    end
    do_reset();
    vectors++; if (free_count !== 7'd32 || alloc_preg !== 6'd32 || overflow_err !== 1'b0 || alloc_rdy !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset: got count=%0d preg=%0d ovf=%b rdy=%b want 32/32/0/1", free_count, alloc_preg, overflow_err, alloc_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, 1'b1, 1'b1, int'($urandom_range(0, DEPTH - 1)));
      exp = exp_q.pop_front();
      vectors++; if (obs_preg !== preg_t'(exp)) begin miscompares++; $display("FAIL b2b[%0d]: got %0d want %0d", i, obs_preg, exp); end
    end
    vectors++; if (free_count !== (W+1)'(model_q.size()) || free_count !== 7'd32) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 32", free_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alloc_three();
    test_drain_bypass();
    test_simultaneous();
    test_no_wen();
    test_overflow_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
